// File: rtl/join_tracker.sv
// Launch/join tracker: starts a set of worker lanes, collects their done pulses and
// reports completion under ALL / ANY / NONE join semantics with elapsed-cycle count.
module join_tracker #(
  parameter int unsigned N_LANES = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               launch_valid,
  output logic               launch_ready,
  input  logic [N_LANES-1:0] launch_mask,
  input  logic [1:0]         launch_mode,
  output logic [N_LANES-1:0] lane_start,
  input  logic [N_LANES-1:0] lane_done,
  output logic               join_valid,
  input  logic               join_ready,
  output logic [N_LANES-1:0] join_lanes,
  output logic [CNT_W-1:0]   join_cycles,
  output logic [N_LANES-1:0] outstanding,
  output logic               busy,
  output logic               err_spurious
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_REPORT,
    S_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    M_ALL     = 2'b00,
    M_ANY     = 2'b01,
    M_NONE    = 2'b10,
    M_ALL_ALT = 2'b11
  } mode_t;

  state_t             r_state, w_state_nx;
  mode_t              r_mode,  w_mode_nx;
  logic [N_LANES-1:0] r_mask,  w_mask_nx;
  logic [N_LANES-1:0] r_out,   w_out_nx;
  logic [N_LANES-1:0] r_seen,  w_seen_nx;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nx;
  logic [N_LANES-1:0] r_jl,    w_jl_nx;
  logic [CNT_W-1:0]   r_jc,    w_jc_nx;
  logic               r_err,   w_err_nx;

  logic [N_LANES-1:0] w_out_upd;
  logic [N_LANES-1:0] w_seen_upd;
  logic [CNT_W-1:0]   w_cnt_sat;
  logic               w_in_launch;
  logic               w_cond_mode;
  logic               w_join;

  // Done tracking runs in every state; the join test sees this cycle's dones.
  always_comb begin
    w_out_upd   = r_out & ~lane_done;
    w_seen_upd  = r_seen | (lane_done & r_out);
    w_cnt_sat   = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    w_in_launch = (r_state == S_START) || (r_state == S_RUN);
    case (r_mode)
      M_ANY:   w_cond_mode = |w_seen_upd;
      M_NONE:  w_cond_mode = (r_state == S_START);
      default: w_cond_mode = (w_out_upd == '0);
    endcase
    w_join = w_in_launch &&
             (w_cond_mode || ((r_state == S_START) && (r_mask == '0)));
  end

  always_comb begin
    w_state_nx = r_state;
    w_mode_nx  = r_mode;
    w_mask_nx  = r_mask;
    w_out_nx   = w_out_upd;
    w_seen_nx  = w_seen_upd;
    w_cnt_nx   = r_cnt;
    w_jl_nx    = r_jl;
    w_jc_nx    = r_jc;
    w_err_nx   = r_err | (|(lane_done & ~r_out));

    case (r_state)
      S_IDLE: begin
        if (launch_valid) begin
          w_state_nx = S_START;
          w_mode_nx  = mode_t'(launch_mode);
          w_mask_nx  = launch_mask;
          w_out_nx   = launch_mask;
          w_seen_nx  = '0;
          w_cnt_nx   = '0;
        end
      end
      S_START, S_RUN: begin
        w_cnt_nx = w_cnt_sat;
        if (w_join) begin
          w_jl_nx    = w_seen_upd;
          w_jc_nx    = r_cnt;
          w_state_nx = S_REPORT;
        end else begin
          w_state_nx = S_RUN;
        end
      end
      S_REPORT: begin
        if (join_ready) begin
          w_state_nx = (w_out_upd == '0) ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_out_upd == '0) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= M_ALL;
      r_mask  <= '0;
      r_out   <= '0;
      r_seen  <= '0;
      r_cnt   <= '0;
      r_jl    <= '0;
      r_jc    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_mode  <= w_mode_nx;
      r_mask  <= w_mask_nx;
      r_out   <= w_out_nx;
      r_seen  <= w_seen_nx;
      r_cnt   <= w_cnt_nx;
      r_jl    <= w_jl_nx;
      r_jc    <= w_jc_nx;
      r_err   <= w_err_nx;
    end
  end

  assign launch_ready = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign join_valid   = (r_state == S_REPORT);
  assign lane_start   = (r_state == S_START) ? r_mask : '0;
  assign join_lanes   = r_jl;
  assign join_cycles  = r_jc;
  assign outstanding  = r_out;
  assign err_spurious = r_err;

endmodule

// File: tb/tb_join_tracker.sv
// Scoreboard bench for join_tracker: randomized launches with per-lane done offsets,
// expected reports derived from join rules (min/max of done offsets) and checked by a monitor.
module tb_join_tracker;

  localparam int NL = 2;
  localparam int CW = 5;

  logic          clk;
  logic          rst_n;
  logic          launch_valid;
  logic          launch_ready;
  logic [NL-1:0] launch_mask;
  logic [1:0]    launch_mode;
  logic [NL-1:0] lane_start;
  logic [NL-1:0] lane_done;
  logic          join_valid;
  logic          join_ready;
  logic [NL-1:0] join_lanes;
  logic [CW-1:0] join_cycles;
  logic [NL-1:0] outstanding;
  logic          busy;
  logic          err_spurious;

  join_tracker #(.N_LANES(NL), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .launch_valid (launch_valid),
    .launch_ready (launch_ready),
    .launch_mask  (launch_mask),
    .launch_mode  (launch_mode),
    .lane_start   (lane_start),
    .lane_done    (lane_done),
    .join_valid   (join_valid),
    .join_ready   (join_ready),
    .join_lanes   (join_lanes),
    .join_cycles  (join_cycles),
    .outstanding  (outstanding),
    .busy         (busy),
    .err_spurious (err_spurious)
  );

  typedef struct {
    logic [NL-1:0] lanes;
    logic [CW-1:0] cycles;
    int            vcyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   hold = 1'b0;
  bit   prev_hold = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    join_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      join_ready = hold ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle a report is presented it must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (join_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_report", 64'(join_valid), 64'd0);
        end else begin
          chk("join_lanes", 64'(join_lanes), 64'(q[0].lanes));
          chk("join_cycles", 64'(join_cycles), 64'(q[0].cycles));
          if (!prev_hold) chk("report_time", 64'(cyc), 64'(q[0].vcyc));
          if (join_ready) void'(q.pop_front());
        end
      end
      prev_hold = join_valid && !join_ready;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 1000 && !launch_ready; i++) @(negedge clk);
    chk("idle_timeout", 64'(launch_ready), 64'd1);
  endtask

  task automatic run_txn(input logic [NL-1:0] mask, input logic [1:0] mode,
                         input int d0, input int d1, input bit t5, input int abort_at);
    int            dd[NL];
    int            kx;
    int            mx;
    logic [NL-1:0] lx;
    logic [NL-1:0] dv;
    logic [NL-1:0] ov;
    exp_t          e;
    dd[0] = d0;
    dd[1] = d1;
    mx = 0;
    for (int i = 0; i < NL; i++) if (mask[i] && dd[i] > mx) mx = dd[i];
    lx = '0;
    if (mask == '0) begin
      kx = 0;
    end else if (mode == 2'b10) begin
      kx = 0;
      for (int i = 0; i < NL; i++) lx[i] = mask[i] && (dd[i] == 0);
    end else if (mode == 2'b01) begin
      kx = 1 << 30;
      for (int i = 0; i < NL; i++) if (mask[i] && dd[i] < kx) kx = dd[i];
      for (int i = 0; i < NL; i++) lx[i] = mask[i] && (dd[i] == kx);
    end else begin
      kx = mx;
      lx = mask;
    end

    hold = t5;
    wait_idle();
    launch_valid = 1'b1;
    launch_mask  = mask;
    launch_mode  = mode;
    @(negedge clk);
    launch_valid = 1'b0;
    launch_mask  = '0;
    chk("lane_start", 64'(lane_start), 64'(mask));
    chk("busy_start", 64'(busy), 64'd1);
    e.lanes  = lx;
    e.cycles = (kx > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(kx);
    e.vcyc   = cyc + kx + 1;
    q.push_back(e);

    for (int k = 0; k <= mx; k++) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("reset_ready", 64'(launch_ready), 64'd1);
        chk("reset_outs", 64'({busy, join_valid, lane_start, join_lanes, join_cycles,
                               outstanding, err_spurious}), 64'd0);
        q.delete();
        lane_done = '0;
        hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      for (int i = 0; i < NL; i++) begin
        ov[i] = mask[i] && (dd[i] >= k);
        dv[i] = mask[i] && (dd[i] == k);
      end
      chk("outstanding", 64'(outstanding), 64'(ov));
      if (k > 0) chk("stall_ready", 64'(launch_ready), 64'd0);
      lane_done = dv;
      @(negedge clk);
    end
    lane_done = '0;

    if (t5) begin
      for (int i = 0; i < 10; i++) begin
        chk("hold_ready", 64'(launch_ready), 64'd0);
        chk("hold_valid", 64'(join_valid), 64'd1);
        if (i == 5) lane_done = 2'b01;
        @(negedge clk);
        lane_done = '0;
      end
      chk("err_spurious", 64'(err_spurious), 64'd1);
      hold = 1'b0;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    launch_valid = 1'b0;
    launch_mask  = '0;
    launch_mode  = 2'b00;
    lane_done    = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(launch_ready), 64'd1);
    chk("rst_outs", 64'({busy, join_valid, lane_start, join_lanes, join_cycles,
                         outstanding, err_spurious}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(2'b11, 2'b00, 20, 30, 1'b0, -1);
    run_txn(2'b11, 2'b01, 20, 30, 1'b0, -1);
    run_txn(2'b11, 2'b10, 3, 7, 1'b0, -1);
    run_txn(2'b00, 2'($urandom_range(0, 3)), 5, 9, 1'b0, -1);
    run_txn(2'b11, 2'b01, 6, 6, 1'b0, -1);
    for (int n = 0; n < 40; n++) begin
      run_txn(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), 1'b0, -1);
    end
    wait_idle();
    chk("no_spurious", 64'(err_spurious), 64'd0);

    run_txn(2'b11, 2'b00, 5, 5, 1'b1, -1);
    run_txn(2'b11, 2'b00, 20, 30, 1'b0, 12);
    run_txn(2'b11, 2'b11, 4, 9, 1'b0, -1);
    wait_idle();
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
